axi4_lite_timer: RTL

//   AXI4-Lite target hung off a crossbar target port (next to the RAM/ROM targets) on i_sysclk.

---
 rtl/axi4_lite_timer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/axi4_lite_timer.sv
// AXI4-Lite timer target: prescaled 32-bit up-counter, compare register and match flag.
// The match flag drives a level interrupt when irq_en is set.
module axi4_lite_timer #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int PRESCALE   = 100
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_AWVALID,
    output logic                  o_AWREADY,
    input  logic [ADDR_WIDTH-1:0] i_AWADDR,
    input  logic [2:0]            i_AWPROT,
    input  logic                  i_WVALID,
    output logic                  o_WREADY,
    input  logic [DATA_WIDTH-1:0] i_WDATA,
    input  logic [3:0]            i_WSTRB,
    output logic                  o_BVALID,
    input  logic                  i_BREADY,
    output logic [1:0]            o_BRESP,
    input  logic                  i_ARVALID,
    output logic                  o_ARREADY,
    input  logic [ADDR_WIDTH-1:0] i_ARADDR,
    input  logic [2:0]            i_ARPROT,
    output logic                  o_RVALID,
    input  logic                  i_RREADY,
    output logic [DATA_WIDTH-1:0] o_RDATA,
    output logic [1:0]            o_RRESP,
    output logic                  o_irq
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        REG_CTRL    = 2'd0,
        REG_STATUS  = 2'd1,
        REG_COUNT   = 2'd2,
        REG_COMPARE = 2'd3
    } reg_sel_e;

    logic [2:0]            ctrl;
    logic                  match;
    logic [DATA_WIDTH-1:0] count;
    logic [DATA_WIDTH-1:0] compare;
    logic [PS_W-1:0]       presc;
    logic                  tick;
    logic                  wr_acc;
    logic                  rd_acc;
    reg_sel_e              wsel;
    reg_sel_e              rsel;
    logic [DATA_WIDTH-1:0] rd_val;

    logic unused_inputs;
    assign unused_inputs = ^{i_AWPROT, i_ARPROT,
                             i_AWADDR[ADDR_WIDTH-1:4], i_AWADDR[1:0],
                             i_ARADDR[ADDR_WIDTH-1:4], i_ARADDR[1:0]};

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_val,
        input logic [DATA_WIDTH-1:0] new_val,
        input logic [3:0]            strb
    );
        logic [DATA_WIDTH-1:0] r;
        r = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
        end
        return r;
    endfunction

    // READY is registered, so a transfer completes on the edge where READY is seen high.
    assign wr_acc = o_AWREADY & i_AWVALID & i_WVALID;
    assign rd_acc = o_ARREADY & i_ARVALID;
    assign wsel   = reg_sel_e'(i_AWADDR[3:2]);
    assign rsel   = reg_sel_e'(i_ARADDR[3:2]);
    assign tick   = ctrl[0] & (presc == PS_LAST);

    assign o_BRESP = 2'b00;
    assign o_RRESP = 2'b00;
    assign o_irq   = match & ctrl[2];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_AWREADY <= 1'b0;
            o_WREADY  <= 1'b0;
            o_BVALID  <= 1'b0;
        end else begin
            o_AWREADY <= i_AWVALID & i_WVALID & ~o_BVALID & ~o_AWREADY;
            o_WREADY  <= i_AWVALID & i_WVALID & ~o_BVALID & ~o_AWREADY;
            if (wr_acc) begin
                o_BVALID <= 1'b1;
            end else if (i_BREADY) begin
                o_BVALID <= 1'b0;
            end
        end
    end

    always_comb begin
        rd_val = '0;
        case (rsel)
            REG_CTRL:    rd_val[2:0] = ctrl;
            REG_STATUS:  rd_val[0]   = match;
            REG_COUNT:   rd_val      = count;
            REG_COMPARE: rd_val      = compare;
            default:     rd_val      = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_ARREADY <= 1'b0;
            o_RVALID  <= 1'b0;
            o_RDATA   <= '0;
        end else begin
            o_ARREADY <= i_ARVALID & ~o_RVALID & ~o_ARREADY;
            if (rd_acc) begin
                o_RVALID <= 1'b1;
                o_RDATA  <= rd_val;
            end else if (i_RREADY) begin
                o_RVALID <= 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            presc <= '0;
        end else if (ctrl[0]) begin
            presc <= tick ? '0 : presc + 1'b1;
        end
    end

    // An AXI write to COUNT wins over the tick; a hardware match wins over a W1C clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ctrl    <= '0;
            match   <= 1'b0;
            count   <= '0;
            compare <= '0;
        end else begin
            if (wr_acc && wsel == REG_CTRL && i_WSTRB[0]) begin
                ctrl <= i_WDATA[2:0];
            end
            if (wr_acc && wsel == REG_COMPARE) begin
                compare <= merge_bytes(compare, i_WDATA, i_WSTRB);
            end
            if (wr_acc && wsel == REG_COUNT) begin
                count <= merge_bytes(count, i_WDATA, i_WSTRB);
            end else if (tick) begin
                count <= (ctrl[1] && count == compare) ? '0 : count + 32'd1;
            end
            if (tick && count == compare) begin
                match <= 1'b1;
            end else if (wr_acc && wsel == REG_STATUS && i_WSTRB[0] && i_WDATA[0]) begin
                match <= 1'b0;
            end
        end
    end

endmodule
